// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the scalar writeback path.
package pipeline_pkg;

  localparam int WB_NREQ = 3;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    regbits_t rd;
    word_t    data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant selection over a request vector, searching upward from ptr.
// Build option: define WB_FIXED_PRIO_EN to ignore ptr and give index 0 the
// highest priority.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   base;
  int   idx;
  logic found;

`ifdef WB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // First requester found walking from base, wrapping modulo N.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
`ifdef WB_FIXED_PRIO_EN
    base  = 0;
`else
    base  = int'(ptr);
`endif
    for (int off = 0; off < N; off++) begin
      idx = (base + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Scalar writeback arbiter: one 1-entry buffer per requester, one register
// file write per cycle, round-robin among full buffers.
// Build option: WB_FIXED_PRIO_EN selects fixed priority (index 0 highest).
// Handshake: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high and flush is low; req_ready does not depend on
// req_valid. A transfer with rd==0 is accepted and silently discarded.
module wb_arbiter
  import pipeline_pkg::*;
#(
  parameter int NREQ = WB_NREQ
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  regbits_t [NREQ-1:0]       req_rd,
  input  word_t [NREQ-1:0]          req_data,
  input  logic                      wb_stall,
  input  logic                      flush,
  output logic                      wb_en,
  output regbits_t                  wb_rd,
  output word_t                     wb_data,
  output logic [$clog2(NREQ)-1:0]   wb_src
);

  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0] buf_valid;
  wb_req_t         buf_q [NREQ];
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] accept;
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   gidx;
  logic [SW-1:0]   ptr_next;
  wb_req_t         sel;
  logic            any_grant;

  // Nothing is granted while the register file stalls or a flush is pending.
  assign arb_req   = buf_valid & {NREQ{!wb_stall && !flush}};
  assign any_grant = |grant;
  assign req_ready = ~buf_valid | grant;
  assign ptr_next  = (gidx == SW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  rr_arbiter #(.N(NREQ), .PW(SW)) u_rr_arbiter (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Transfers that actually fill a buffer (rd==0 writes are dropped here).
  always_comb begin
    accept = '0;
    for (int i = 0; i < NREQ; i++) begin
      accept[i] = req_valid[i] && req_ready[i] && !flush && (req_rd[i] != '0);
    end
  end

  // Encode the one-hot grant and mux out the granted buffer.
  always_comb begin
    gidx = '0;
    sel  = buf_q[0];
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx = SW'(i);
        sel  = buf_q[i];
      end
    end
  end

  // Buffer fill/drain; a granted buffer may refill on the same edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_valid <= '0;
      for (int i = 0; i < NREQ; i++) buf_q[i] <= '0;
    end else if (flush) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_q[i]     <= '{rd: req_rd[i], data: req_data[i]};
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Registered write port and rotation pointer; outputs hold when idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_src  <= '0;
      rr_ptr  <= '0;
    end else begin
      wb_en <= any_grant;
      if (any_grant) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
        wb_src  <= gidx;
`ifdef WB_FIXED_PRIO_EN
        rr_ptr  <= '0;
`else
        rr_ptr  <= ptr_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic,
// checked against a request-level model of buffers and rotation.
module tb_wb_arbiter;

  logic             CLK;
  logic             nRST;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0][4:0]  req_rd;
  logic [2:0][31:0] req_data;
  logic             wb_stall;
  logic             flush;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [1:0]       wb_src;

  wb_arbiter #(.NREQ(3)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .wb_stall  (wb_stall),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_src    (wb_src)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // scoreboard: {src, rd, data}
  logic [38:0] exp_q[$];
  logic [38:0] last_w;
  logic        exp_en;
  logic        mon_on;

  // reference model: pending write per requester, next requester to favour
  bit          m_valid [3];
  logic [4:0]  m_rd    [3];
  logic [31:0] m_data  [3];
  int          m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0;
      m_rd[i]    = '0;
      m_data[i]  = '0;
    end
    m_ptr  = 0;
    exp_q.delete();
    exp_en = 1'b0;
    last_w = '0;
  endtask

  // Called just after a falling edge with inputs already applied; predicts
  // the coming rising edge, checks req_ready, and returns at the next fall.
  task automatic step();
    int  g;
    bit  rdy [3];
    #1;
    g = -1;
    if (!wb_stall && !flush) begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_ptr + k) % 3;
        if (g < 0 && m_valid[i]) g = i;
      end
    end
    for (int i = 0; i < 3; i++) begin
      rdy[i] = !m_valid[i] || (g == i);
      chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(rdy[i]));
    end
    if (flush || !nRST) begin
      for (int i = 0; i < 3; i++) m_valid[i] = 0;
    end else begin
      if (g >= 0) begin
        m_valid[g] = 0;
        exp_q.push_back({2'(g), m_rd[g], m_data[g]});
        m_ptr = (g + 1) % 3;
      end
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && rdy[i] && req_rd[i] != 5'd0) begin
          m_valid[i] = 1;
          m_rd[i]    = req_rd[i];
          m_data[i]  = req_data[i];
        end
      end
    end
    exp_en = (g >= 0) && nRST;
    @(negedge CLK);
  endtask

  task automatic idle();
    req_valid = '0;
    wb_stall  = 1'b0;
    flush     = 1'b0;
  endtask

  // monitor: compares the write port after every rising edge
  always @(posedge CLK) begin
    if (mon_on) begin
      logic [38:0] e;
      #1;
      chk("wb_en", 64'(wb_en), 64'(exp_en));
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 64'({wb_src, wb_rd, wb_data}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wb_write", 64'({wb_src, wb_rd, wb_data}), 64'(e));
          last_w = e;
        end
      end else begin
        chk("wb_hold", 64'({wb_src, wb_rd, wb_data}), 64'(last_w));
      end
    end
  end

  initial begin
    mon_on   = 1'b0;
    nRST     = 1'b0;
    req_rd   = '0;
    req_data = '0;
    idle();
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_wb_en",   64'(wb_en),     64'(0));
    chk("rst_wb_rd",   64'(wb_rd),     64'(0));
    chk("rst_wb_data", 64'(wb_data),   64'(0));
    chk("rst_wb_src",  64'(wb_src),    64'(0));
    chk("rst_ready",   64'(req_ready), 64'(3'b111));
    nRST   = 1'b1;
    mon_on = 1'b1;

    // single ALU write
    req_valid = 3'b001; req_rd[0] = 5'd5; req_data[0] = 32'hDEADBEEF;
    step();
    idle();
    repeat (3) step();

    // all three requesters every cycle: rotation 0,1,2,...
    for (int c = 0; c < 9; c++) begin
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
        req_rd[i]   = 5'(1 + i + 3 * (c % 3));
        req_data[i] = 32'(c * 16 + i);
      end
      step();
    end
    idle();
    repeat (4) step();

    // rd==0 is accepted and dropped
    req_valid = 3'b001; req_rd[0] = 5'd0; req_data[0] = 32'h1234;
    step();
    idle();
    repeat (4) step();

    // stall with buffers 0 and 1 full, then release
    req_valid = 3'b011; req_rd[0] = 5'd7; req_rd[1] = 5'd8;
    req_data[0] = 32'hA0; req_data[1] = 32'hB1; wb_stall = 1'b1;
    step();
    req_valid = '0;
    repeat (2) step();
    idle();
    repeat (4) step();

    // flush with buffers 1,2 full and a new request on 0
    req_valid = 3'b110; req_rd[1] = 5'd9; req_rd[2] = 5'd10; wb_stall = 1'b1;
    step();
    req_valid = 3'b001; req_rd[0] = 5'd11; wb_stall = 1'b0; flush = 1'b1;
    step();
    idle();
    repeat (3) step();

    // asynchronous reset mid-stream
    req_valid = 3'b111; req_rd[0] = 5'd12; req_rd[1] = 5'd13; req_rd[2] = 5'd14;
    wb_stall = 1'b1;
    step();
    idle();
    step();
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("async_rst_wb_en", 64'(wb_en),     64'(0));
    chk("async_rst_ready", 64'(req_ready), 64'(3'b111));
    @(negedge CLK);
    step();
    nRST = 1'b1;
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        req_rd[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        req_data[i] = $urandom;
      end
      wb_stall = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      step();
    end
    idle();
    repeat (5) step();

    mon_on = 1'b0;
    chk("drain", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter: NREQ, default 3, number of scalar writeback requesters (0=scalar ALU, 1=scalar LS, 2=branch link).
REQ-002 SHALL have port: CLK  input  1  system clock, rising edge.
REQ-003 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  NREQ  per-requester writeback request.
REQ-005 SHALL have port: req_ready  output  NREQ  per-requester accept.
REQ-006 SHALL have port: req_rd  input  NREQ x 5  destination register (regbits_t).
REQ-007 SHALL have port: req_data  input  NREQ x 32  writeback data (word_t).
REQ-008 SHALL have port: wb_stall  input  1  register file cannot accept a write this cycle.
REQ-009 SHALL have port: flush  input  1  discard all pending writebacks.
REQ-010 SHALL have port: wb_en  output  1  scalar register write enable.
REQ-011 SHALL have port: wb_rd  output  5  write register index.
REQ-012 SHALL have port: wb_data  output  32  write data.
REQ-013 SHALL have port: wb_src  output  $clog2(NREQ)  index of requester whose write is on wb_*.

Function
REQ-014 SHALL hold one 1-entry buffer per requester (valid, rd, data).
REQ-015 SHALL drive req_ready[i] = !buf_valid[i] | grant[i], combinationally, independent of req_valid.
REQ-016 SHALL capture req_rd/req_data into buffer i on the edge where req_valid[i] & req_ready[i] & !flush.
REQ-017 SHALL complete a request with req_rd==0 as accepted and dropped: no buffer fill, no grant, no wb_en.
REQ-018 SHALL grant at most one valid buffer per cycle when !wb_stall & !flush, round-robin, search starting at rr_ptr.
REQ-019 SHALL set rr_ptr to (granted index + 1) mod NREQ after a grant; rr_ptr unchanged when no grant.
REQ-020 SHALL register wb_en/wb_rd/wb_data/wb_src on the edge following the grant; wb_en high exactly one cycle per grant.
REQ-021 SHALL give latency: request accepted at edge N -> buffer valid cycle N+1 -> wb_en high cycle N+2 (when uncontended, unstalled).
REQ-022 SHALL allow a granted buffer to refill on the same edge (grant and accept simultaneous), yielding one write per cycle per requester sustained.
REQ-023 SHALL hold wb_en=0 for the cycle after a wb_stall cycle and keep all buffers and rr_ptr unchanged during wb_stall.
REQ-024 SHALL, on flush, clear all buffer valids and wb_en at the next edge; flush overrides simultaneous accept and grant.
REQ-025 SHALL hold wb_rd/wb_data/wb_src at last values when wb_en=0.

Reset
REQ-026 SHALL, on nRST low (asynchronous), clear all buf_valid, rr_ptr=0, wb_en=0, wb_rd=0, wb_data=0, wb_src=0.
REQ-027 SHALL drop in-flight buffered requests on reset mid-operation; req_ready all 1 while in reset.

Configuration
REQ-028 SHALL, with WB_FIXED_PRIO_EN defined, use fixed priority (lowest index wins) with rr_ptr held at 0.
REQ-029 SHALL, without WB_FIXED_PRIO_EN, use round-robin per REQ-018/REQ-019.

Structure
REQ-030 SHALL define wb_req_t (regbits_t rd, word_t data) and constant WB_NREQ=3 in pipeline_pkg.
REQ-031 SHALL instantiate one sub-module rr_arbiter (request vector, pointer -> one-hot grant), also implementing the fixed-priority mode.

Verification
REQ-032 SHALL cover: single ALU req rd=5 data=0xDEADBEEF at edge 0 -> wb_en=1, wb_rd=5, wb_data=0xDEADBEEF, wb_src=0 in cycle 2.
REQ-033 SHALL cover: all three requesters valid every cycle from rr_ptr=0 -> wb_src sequence 0,1,2,0,1,2; each req_ready high once per 3 cycles.
REQ-034 SHALL cover: req rd=0 data=0x1234 -> req_ready=1, no wb_en within 4 cycles.
REQ-035 SHALL cover: buffers 0,1 valid, wb_stall high 3 cycles -> wb_en=0 throughout, then writes 0 then 1 after release.
REQ-036 SHALL cover: flush with buffers 1,2 valid and new req on 0 same cycle -> no wb_en in next 3 cycles, all req_ready=1.
REQ-037 SHALL cover: nRST low mid-stream with 2 buffers valid -> wb_en=0 immediately; no writes after nRST release without new requests.
